ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
//  Sequences the configuration-chain (CCFF) load for the fabric. Accepts bitstream words over a
//  valid/ready stream and serialises them, LSB first, onto the chain head with a per-bit shift enable.
//  Deserialises the old chain contents leaving ccff_tail into readback words. Sits between the
//  bitstream source and the chain of configuration flops behind the buf4/tap_buf4 programming buffers.
// PARAMETERS
//  CHAIN_LEN  64  number of flops in the chain; bits shifted per load (>=1)
//  WORD_W     8   bitstream/readback word width (>=2)
//  CNT_W      $clog2(CHAIN_LEN+1)  bit_count width (derived, do not override)
// PORTS
//  prog_clk   in   1        programming clock; all state on rising edge
//  pReset     in   1        synchronous, active-high reset
//  start      in   1        1-cycle request to begin a load; ignored unless IDLE or DONE
//  bs_data    in   WORD_W   bitstream word, bit 0 shifted first
//  bs_valid   in   1        bs_data valid
//  bs_ready   out  1        loader accepts word when bs_valid&bs_ready
//  ccff_head  out  1        serial data into chain head
//  shift_en   out  1        chain shifts ccff_head in at the edge ending a cycle with shift_en=1
//  ccff_tail  in   1        chain tail; sampled in every shift_en=1 cycle, before that edge
//  rb_data    out  WORD_W   readback word, first tail bit in bit 0
//  rb_valid   out  1        1-cycle pulse, rb_data valid (no backpressure)
//  busy       out  1        high in FETCH and SHIFT
//  done       out  1        high in DONE
//  bit_count  out  CNT_W    bits shifted in current/last load
// BEHAVIOUR
//  Reset (pReset=1 at an edge): state IDLE. All outputs 0; word register and readback register cleared.
//   Reset mid-load abandons the load; the chain keeps whatever was already shifted.
//  States: IDLE, FETCH, SHIFT, DONE (encoding free).
//  IDLE/DONE:
//   - start=1 -> FETCH; bit_count cleared to 0; done drops the cycle after start.
//   - DONE holds done=1 until start or reset.
//  FETCH:
//   - bs_ready=1, shift_en=0.
//   - On bs_valid&bs_ready, load word register and go to SHIFT; otherwise stay (source stall allowed).
//  SHIFT: shift_en=1; ccff_head = word_reg[word_bit]; bit_count++ and word_bit++ per cycle.
//   - Prefetch: bs_ready=1 on the last bit of a word (word_bit==WORD_W-1) when bit_count+1<CHAIN_LEN.
//   - Prefetch accepted: next word loads and shifting continues with no bubble.
//   - Prefetch not accepted: go to FETCH (shift_en=0 bubble until a word arrives).
//   - When bit_count+1==CHAIN_LEN in this cycle: go to DONE after this cycle. bs_ready=0 in that
//     cycle; unused high bits of the final word are discarded.
//  Latency/throughput:
//   - Word accepted at edge t -> its bit 0 on ccff_head with shift_en=1 in cycle t+1.
//   - Back-to-back valid gives exactly CHAIN_LEN consecutive shift cycles.
//   - done rises the cycle after the last shift cycle.
//  Readback:
//   - Each shift cycle stores ccff_tail into rb bit position (bit_count mod WORD_W).
//   - When WORD_W bits have been collected, rb_data updates and rb_valid pulses in the next cycle.
//   - Final partial word (CHAIN_LEN mod WORD_W != 0): emitted zero-padded, in the same cycle done rises.
//   - rb_data holds its value between pulses.
//  Simultaneous events:
//   - pReset dominates everything.
//   - start while busy is ignored.
//   - start in the same cycle as entry to DONE is ignored (DONE is observed first).
//  bs_ready and shift_en are never high outside FETCH/SHIFT. bs_ready never depends combinationally
//   on bs_valid.
// TESTING (CHAIN_LEN=20, WORD_W=8 unless noted; chain model = 20-bit shift register preloaded)
//  1. Reset: hold pReset 3 cycles mid-SHIFT -> all outputs 0 next cycle, bit_count=0, state IDLE.
//  2. Continuous load:
//     - Stimulus: start, words 0xA5,0x3C,0x0F with bs_valid always 1.
//     - Response: 20 consecutive shift_en cycles; head bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,1,1,1,1;
//       done 1 cycle later; bit_count=20.
//  3. Readback:
//     - Stimulus: chain preloaded 0xFFFFF, then the load of test 2.
//     - Response: rb_valid pulses with 0xFF, 0xFF, then 0x0F (padded, same cycle as done);
//       chain equals loaded pattern.
//  4. Source stall:
//     - Stimulus: bs_valid low 5 cycles before the second word.
//     - Response: shift_en=0 for those cycles, bs_ready=1, no head bits lost; same final chain content.
//  5. start during SHIFT and start in DONE:
//     - Response: first ignored (bit_count unaffected); second clears done and bit_count
//       and reenters FETCH.
//  6. CHAIN_LEN=8, WORD_W=8:
//     - Stimulus: one word 0x81.
//     - Response: 8 shift cycles, bs_ready never asserted during SHIFT, one rb_valid, done.

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccff_chain_loader_if : stream, chain and status bundle of the CCFF loader |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 7
);
  logic              start;
  logic [WORD_W-1:0] bs_data;
  logic              bs_valid;
  logic              bs_ready;
  logic              ccff_head;
  logic              shift_en;
  logic              ccff_tail;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bit_count;

  // master is the loader itself; slave is the bitstream source / chain side
  modport master (
    input  start, bs_data, bs_valid, ccff_tail,
    output bs_ready, ccff_head, shift_en, rb_data, rb_valid, busy, done, bit_count
  );

  modport slave (
    output start, bs_data, bs_valid, ccff_tail,
    input  bs_ready, ccff_head, shift_en, rb_data, rb_valid, busy, done, bit_count
  );
endinterface
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccff_chain_loader : serialises bitstream words onto the CCFF chain, LSB   |
// | first, and packs the displaced tail bits into readback words. Rev 1.0    |
// +--------------------------------------------------------------------------+
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                prog_clk,
  input  logic                pReset,
  ccff_chain_loader_if.master bus
);

  localparam int              WB_W       = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [WB_W-1:0]  C_LAST_BIT = WB_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q,     state_d;
  logic [WORD_W-1:0] word_q,      word_d;
  logic [WB_W-1:0]   word_bit_q,  word_bit_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic [WORD_W-1:0] rb_acc_q,    rb_acc_d;
  logic [WORD_W-1:0] rb_data_q,   rb_data_d;
  logic              rb_valid_q,  rb_valid_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic              last_chain_bit;
  logic              last_word_bit;
  logic [WORD_W-1:0] rb_merged;
  logic              bs_ready_w;

  always_comb begin
    cnt_inc        = bit_count_q + CNT_W'(1);
    last_chain_bit = (cnt_inc == C_LAST_CNT);
    last_word_bit  = (word_bit_q == C_LAST_BIT);

    // word_bit tracks bit_count mod WORD_W, so a fresh readback word starts at
    // word_bit==0; starting from zero gives the padding of a final partial word.
    rb_merged             = (word_bit_q == '0) ? '0 : rb_acc_q;
    rb_merged[word_bit_q] = bus.ccff_tail;

    state_d     = state_q;
    word_d      = word_q;
    word_bit_d  = word_bit_q;
    bit_count_d = bit_count_q;
    rb_acc_d    = rb_acc_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;
    bs_ready_w  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d     = ST_FETCH;
          bit_count_d = '0;
          word_bit_d  = '0;
          rb_acc_d    = '0;
        end
      end

      ST_FETCH: begin
        bs_ready_w = 1'b1;
        if (bus.bs_valid) begin
          word_d  = bus.bs_data;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        bit_count_d = cnt_inc;
        rb_acc_d    = rb_merged;
        word_bit_d  = last_word_bit ? '0 : word_bit_q + WB_W'(1);
        if (last_word_bit || last_chain_bit) begin
          rb_data_d  = rb_merged;
          rb_valid_d = 1'b1;
        end
        if (last_chain_bit) begin
          state_d = ST_DONE;
        end else if (last_word_bit) begin
          // prefetch the next word so back-to-back words shift without a bubble
          bs_ready_w = 1'b1;
          if (bus.bs_valid) begin
            word_d = bus.bs_data;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      word_bit_q  <= '0;
      bit_count_q <= '0;
      rb_acc_q    <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      word_bit_q  <= word_bit_d;
      bit_count_q <= bit_count_d;
      rb_acc_q    <= rb_acc_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
    end
  end

  assign bus.bs_ready  = bs_ready_w;
  assign bus.shift_en  = (state_q == ST_SHIFT);
  assign bus.ccff_head = (state_q == ST_SHIFT) & word_q[word_bit_q];
  assign bus.busy      = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.rb_data   = rb_data_q;
  assign bus.rb_valid  = rb_valid_q;
  assign bus.bit_count = bit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// Directed bench: a 20-flop and an 8-flop loader, each driving a shift-register chain model.
module tb_ccff_chain_loader;

  logic prog_clk;
  logic pReset;
  logic sel;
  logic start;
  logic bs_valid;
  logic [7:0] bs_data;

  ccff_chain_loader_if #(.WORD_W(8), .CNT_W(5)) if20 ();
  ccff_chain_loader_if #(.WORD_W(8), .CNT_W(4)) if8 ();

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut20 (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .bus      (if20)
  );

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut8 (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .bus      (if8)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  assign if20.start    = start & ~sel;
  assign if8.start     = start & sel;
  assign if20.bs_valid = bs_valid & ~sel;
  assign if8.bs_valid  = bs_valid & sel;
  assign if20.bs_data  = bs_data;
  assign if8.bs_data   = bs_data;

  // Chain models: head enters bit 0, tail is the top bit.
  logic [19:0] chain20;
  logic [7:0]  chain8;
  logic        pre20_en, pre8_en;
  logic [19:0] pre_val;

  always @(posedge prog_clk) begin
    if (pre20_en)           chain20 <= pre_val;
    else if (if20.shift_en) chain20 <= {chain20[18:0], if20.ccff_head};
    if (pre8_en)            chain8  <= pre_val[7:0];
    else if (if8.shift_en)  chain8  <= {chain8[6:0], if8.ccff_head};
  end

  assign if20.ccff_tail = chain20[19];
  assign if8.ccff_tail  = chain8[7];

  logic       obs_ready, obs_shift, obs_head, obs_rb_valid, obs_busy, obs_done;
  logic [7:0] obs_rb_data, obs_cnt;

  assign obs_ready    = sel ? if8.bs_ready  : if20.bs_ready;
  assign obs_shift    = sel ? if8.shift_en  : if20.shift_en;
  assign obs_head     = sel ? if8.ccff_head : if20.ccff_head;
  assign obs_rb_valid = sel ? if8.rb_valid  : if20.rb_valid;
  assign obs_rb_data  = sel ? if8.rb_data   : if20.rb_data;
  assign obs_busy     = sel ? if8.busy      : if20.busy;
  assign obs_done     = sel ? if8.done      : if20.done;
  assign obs_cnt      = sel ? {4'b0, if8.bit_count} : {3'b0, if20.bit_count};

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Results of the most recent run_load
  int          n_shift, n_bubble, bubble_not_ready, rb_n, first_gap, done_gap;
  logic        ready_in_shift, rb_at_done, timed_out;
  logic [31:0] head_vec;
  logic [7:0]  rb_words [0:7];

  task automatic step;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic preload(input logic use8, input logic [19:0] v);
    pre_val  = v;
    pre20_en = ~use8;
    pre8_en  = use8;
    step();
    pre20_en = 1'b0;
    pre8_en  = 1'b0;
  endtask

  // Entered in the first FETCH cycle; runs the source until done or a cycle budget.
  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input int nwords, input int stall, input int st1, input int st2);
    int   idx, stall_left, cyc, first_shift, last_shift, accept_cyc;
    logic v, accept;
    idx = 0; stall_left = stall; cyc = 0;
    first_shift = -1; last_shift = -1; accept_cyc = -1;
    n_shift = 0; n_bubble = 0; bubble_not_ready = 0; rb_n = 0;
    ready_in_shift = 1'b0; rb_at_done = 1'b0; head_vec = '0;
    while (!obs_done && cyc < 200) begin
      start = 1'b0;
      if (obs_shift) begin
        if (first_shift < 0) first_shift = cyc;
        last_shift = cyc;
        if (n_shift < 32) head_vec[n_shift] = obs_head;
        if (obs_ready) ready_in_shift = 1'b1;
        if (n_shift == st1 || n_shift == st2) start = 1'b1;
        n_shift++;
      end else if (first_shift >= 0) begin
        n_bubble++;
        if (!obs_ready) bubble_not_ready++;
      end
      if (obs_rb_valid && rb_n < 8) begin
        rb_words[rb_n] = obs_rb_data;
        rb_n++;
      end
      v = 1'b0;
      if (idx < nwords) begin
        if (idx == 1 && stall_left > 0 && obs_ready) stall_left--;
        else v = 1'b1;
      end
      bs_valid = v;
      bs_data  = (idx == 0) ? w0 : (idx == 1) ? w1 : w2;
      accept   = v & obs_ready;
      if (accept && accept_cyc < 0) accept_cyc = cyc;
      step();
      cyc++;
      if (accept) idx++;
    end
    start     = 1'b0;
    bs_valid  = 1'b0;
    timed_out = ~obs_done;
    if (obs_rb_valid && rb_n < 8) begin
      rb_words[rb_n] = obs_rb_data;
      rb_n++;
      rb_at_done = 1'b1;
    end
    first_gap = first_shift - accept_cyc;
    done_gap  = cyc - last_shift;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"},    obs_ready,    0);
    check_eq({tag, "_shift"},    obs_shift,    0);
    check_eq({tag, "_head"},     obs_head,     0);
    check_eq({tag, "_busy"},     obs_busy,     0);
    check_eq({tag, "_done"},     obs_done,     0);
    check_eq({tag, "_rb_valid"}, obs_rb_valid, 0);
    check_eq({tag, "_rb_data"},  obs_rb_data,  0);
    check_eq({tag, "_cnt"},      obs_cnt,      0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    sel = 1'b0; start = 1'b0; bs_valid = 1'b0; bs_data = '0;
    pre20_en = 1'b0; pre8_en = 1'b0; pre_val = '0;
    pReset = 1'b1;
    repeat (3) step();
    check_all_zero("por");
    pReset = 1'b0;

    // Reset in the middle of a load
    preload(1'b0, 20'hFFFFF);
    pulse_start();
    bs_valid = 1'b1;
    bs_data  = 8'hA5;
    repeat (12) step();
    check_eq("t1_mid_cnt",   obs_cnt,     11);
    check_eq("t1_mid_shift", obs_shift,   1);
    check_eq("t1_mid_rb",    obs_rb_data, 8'hFF);
    bs_valid = 1'b0;
    pReset   = 1'b1;
    repeat (3) step();
    check_all_zero("t1_rst");
    pReset = 1'b0;
    step();
    check_all_zero("t1_idle");

    // Continuous load with readback of an all-ones chain
    preload(1'b0, 20'hFFFFF);
    pulse_start();
    run_load(8'hA5, 8'h3C, 8'h0F, 3, 0, -1, -1);
    check_eq("t2_timeout",  timed_out, 0);
    check_eq("t2_shifts",   n_shift,   20);
    check_eq("t2_head",     head_vec,  32'h000F3CA5);
    check_eq("t2_bubbles",  n_bubble,  0);
    check_eq("t2_first_lat", first_gap, 1);
    check_eq("t2_done_lat", done_gap,  1);
    check_eq("t2_cnt",      obs_cnt,   20);
    check_eq("t2_busy",     obs_busy,  0);
    check_eq("t3_rb_n",     rb_n,      3);
    check_eq("t3_rb0",      rb_words[0], 8'hFF);
    check_eq("t3_rb1",      rb_words[1], 8'hFF);
    check_eq("t3_rb2",      rb_words[2], 8'h0F);
    check_eq("t3_rb_at_done", rb_at_done, 1);
    check_eq("t3_chain",    chain20,   20'hA53CF);

    // Source stall of 5 cycles ahead of the second word; readback returns the previous load
    pulse_start();
    run_load(8'hA5, 8'h3C, 8'h0F, 3, 5, -1, -1);
    check_eq("t4_timeout",  timed_out, 0);
    check_eq("t4_shifts",   n_shift,   20);
    check_eq("t4_head",     head_vec,  32'h000F3CA5);
    check_eq("t4_bubbles",  n_bubble,  5);
    check_eq("t4_bubble_rdy", bubble_not_ready, 0);
    check_eq("t4_rb_n",     rb_n,      3);
    check_eq("t4_rb0",      rb_words[0], 8'hA5);
    check_eq("t4_rb1",      rb_words[1], 8'h3C);
    check_eq("t4_rb2",      rb_words[2], 8'h0F);
    check_eq("t4_chain",    chain20,   20'hA53CF);
    check_eq("t4_cnt",      obs_cnt,   20);

    // start while shifting (incl. the last shift cycle) is ignored; start in DONE restarts
    pulse_start();
    run_load(8'hA5, 8'h3C, 8'h0F, 3, 0, 5, 19);
    check_eq("t5_timeout",  timed_out, 0);
    check_eq("t5_shifts",   n_shift,   20);
    check_eq("t5_cnt",      obs_cnt,   20);
    check_eq("t5_done_lat", done_gap,  1);
    repeat (2) step();
    check_eq("t5_done_hold", obs_done, 1);
    check_eq("t5_cnt_hold",  obs_cnt,  20);
    pulse_start();
    check_eq("t5_rs_done",  obs_done,  0);
    check_eq("t5_rs_cnt",   obs_cnt,   0);
    check_eq("t5_rs_busy",  obs_busy,  1);
    check_eq("t5_rs_ready", obs_ready, 1);
    check_eq("t5_rs_shift", obs_shift, 0);
    run_load(8'hA5, 8'h3C, 8'h0F, 3, 0, -1, -1);
    check_eq("t5_rs_shifts", n_shift,  20);
    check_eq("t5_rs_chain",  chain20,  20'hA53CF);

    // Single-word chain: CHAIN_LEN == WORD_W
    sel = 1'b1;
    preload(1'b1, 20'h0003A);
    pulse_start();
    run_load(8'h81, 8'h00, 8'h00, 1, 0, -1, -1);
    check_eq("t6_timeout",  timed_out, 0);
    check_eq("t6_shifts",   n_shift,   8);
    check_eq("t6_head",     head_vec,  32'h81);
    check_eq("t6_ready_in_shift", ready_in_shift, 0);
    check_eq("t6_rb_n",     rb_n,      1);
    check_eq("t6_rb0",      rb_words[0], 8'h5C);
    check_eq("t6_rb_at_done", rb_at_done, 1);
    check_eq("t6_chain",    chain8,    8'h81);
    check_eq("t6_cnt",      obs_cnt,   8);
    check_eq("t6_done",     obs_done,  1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
